// File: rtl/reg_file.sv
// +------------------------------------------------------------------------+
// | Module      : reg_file                                                 |
// | Description : 32 x WIDTH register file with a busy scoreboard, x0 tied |
// |               to zero. Define REGFILE_BYPASS_EN for write-through.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module reg_file #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [31:0]      issue_en,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic [31:0]      busy_vec
);

    localparam int C_NUM_PORTS = 2;

    logic [WIDTH-1:0] r_regs_q [1:31];
    logic [WIDTH-1:0] w_regs_d [1:31];
    logic [31:1]      r_busy_q;
    logic [31:1]      w_busy_d;

    logic [WIDTH-1:0] w_rd_view [0:31];
    logic [31:0]      w_busy_full;
    logic [4:0]       w_addr [0:C_NUM_PORTS-1];

    // Strobe bit 0 targets the hardwired-zero register and carries no meaning.
    logic             w_unused_ok;
    assign w_unused_ok = &{1'b0, wr_en[0], issue_en[0]};

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            w_regs_d[i] = wr_en[i] ? wr_data : r_regs_q[i];
            // A same-cycle issue outranks write-back: the newer producer is pending.
            w_busy_d[i] = issue_en[i] | (r_busy_q[i] & ~wr_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs_q[i] <= '0;
            end
            r_busy_q <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                r_regs_q[i] <= w_regs_d[i];
            end
            r_busy_q <= w_busy_d;
        end
    end

    always_comb begin
        w_rd_view[0] = '0;
        for (int i = 1; i < 32; i++) begin
            w_rd_view[i] = r_regs_q[i];
        end
    end

    assign w_busy_full = {r_busy_q, 1'b0};
    assign busy_vec    = w_busy_full;

    assign w_addr[0] = rs1_addr;
    assign w_addr[1] = rs2_addr;

    generate
        for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
            logic [WIDTH-1:0] w_data;
            logic             w_busy;

            always_comb begin
                w_data = w_rd_view[w_addr[p]];
                w_busy = w_busy_full[w_addr[p]];
`ifdef REGFILE_BYPASS_EN
                if ((w_addr[p] != 5'd0) && wr_en[w_addr[p]]) begin
                    w_data = wr_data;
                    w_busy = issue_en[w_addr[p]] & w_busy_full[w_addr[p]];
                end
`else
`endif
            end
        end
    endgenerate

    assign rs1_data = g_port[0].w_data;
    assign rs1_busy = g_port[0].w_busy;
    assign rs2_data = g_port[1].w_data;
    assign rs2_busy = g_port[1].w_busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// +------------------------------------------------------------------------+
// | Module      : tb_reg_file                                              |
// | Description : Directed plus randomized bench for reg_file against an   |
// |               array-based reference model.                             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_reg_file;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [31:0]      issue_en;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [31:0]      busy_vec;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] m_regs [32];
    bit               m_busy [32];

    always #5 clk = ~clk;

    reg_file #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .issue_en (issue_en),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .busy_vec (busy_vec)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_data(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en[a]) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic ref_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en[a]) return issue_en[a] & m_busy[a];
`endif
        return m_busy[a];
    endfunction

    function automatic logic [31:0] ref_busy_vec();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic drive(input logic [31:0] we, input logic [WIDTH-1:0] wd,
                         input logic [31:0] ie, input logic [4:0] a1, input logic [4:0] a2);
        wr_en    = we;
        wr_data  = wd;
        issue_en = ie;
        rs1_addr = a1;
        rs2_addr = a2;
    endtask

    task automatic settle_and_check(input string tag);
        #2;
        chk({tag, ".rs1_data"}, 64'(rs1_data), 64'(ref_data(int'(rs1_addr))));
        chk({tag, ".rs2_data"}, 64'(rs2_data), 64'(ref_data(int'(rs2_addr))));
        chk({tag, ".rs1_busy"}, 64'(rs1_busy), 64'(ref_busy(int'(rs1_addr))));
        chk({tag, ".rs2_busy"}, 64'(rs2_busy), 64'(ref_busy(int'(rs2_addr))));
        chk({tag, ".busy_vec"}, 64'(busy_vec), 64'(ref_busy_vec()));
    endtask

    // Advance one clock and apply the architectural update rules to the model.
    task automatic clock_model();
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            if (reset) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end else if (i != 0) begin
                if (wr_en[i]) m_regs[i] = wr_data;
                if (issue_en[i])   m_busy[i] = 1'b1;
                else if (wr_en[i]) m_busy[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_strobe();
        case ($urandom_range(0, 5))
            0, 1:    return 32'd0;
            2, 3, 4: return 32'd1 << $urandom_range(0, 31);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] we;
        logic [4:0]  a1;
        logic [4:0]  a2;

        reset = 1'b1;
        drive(32'd0, '0, 32'd0, 5'd0, 5'd0);
        clock_model();
        reset = 1'b0;

        drive(32'd0, '0, 32'd0, 5'd5, 5'd31);
        settle_and_check("reset_read");
        chk("reset_lit.rs1", 64'(rs1_data), 64'd0);
        chk("reset_lit.bv", 64'(busy_vec), 64'd0);
        clock_model();

        drive(32'd1 << 7, 32'hDEADBEEF, 32'd0, 5'd7, 5'd0);
        settle_and_check("wr7");
        clock_model();
        drive(32'd1, 32'h1234, 32'd0, 5'd7, 5'd0);
        settle_and_check("wr0");
        chk("rd7_lit", 64'(rs1_data), 64'hDEADBEEF);
        clock_model();
        drive(32'd0, '0, 32'd0, 5'd7, 5'd0);
        settle_and_check("rd0");
        chk("rd0_lit", 64'(rs2_data), 64'd0);
        clock_model();

        drive(32'd0, '0, 32'd1 << 3, 5'd3, 5'd3);
        settle_and_check("iss3");
        clock_model();
        drive(32'd0, '0, 32'd0, 5'd3, 5'd3);
        settle_and_check("busy3");
        chk("busy3_lit", 64'(rs1_busy), 64'd1);
        clock_model();
        drive(32'd1 << 3, 32'h55, 32'd0, 5'd7, 5'd3);
        settle_and_check("wb3");
        clock_model();
        drive(32'd0, '0, 32'd0, 5'd3, 5'd7);
        settle_and_check("post_wb3");
        chk("post_wb3_busy", 64'(rs1_busy), 64'd0);
        chk("post_wb3_data", 64'(rs1_data), 64'h55);
        clock_model();

        drive(32'd0, '0, 32'd1 << 9, 5'd9, 5'd0);
        settle_and_check("iss9");
        clock_model();
        drive(32'd1 << 9, 32'h99, 32'd1 << 9, 5'd9, 5'd9);
        settle_and_check("wb_iss9");
        clock_model();
        drive(32'd0, '0, 32'd0, 5'd9, 5'd0);
        settle_and_check("post9");
        chk("post9_busy", 64'(busy_vec[9]), 64'd1);
        chk("post9_data", 64'(rs1_data), 64'h99);
        clock_model();

        drive(32'd1 << 4, 32'h11, 32'd0, 5'd0, 5'd0);
        settle_and_check("wr4a");
        clock_model();
        drive(32'd1 << 4, 32'h22, 32'd0, 5'd4, 5'd4);
        settle_and_check("bypass4");
`ifdef REGFILE_BYPASS_EN
        chk("bypass4_lit", 64'(rs1_data), 64'h22);
`else
        chk("bypass4_lit", 64'(rs1_data), 64'h11);
`endif
        clock_model();
        drive(32'd0, '0, 32'd0, 5'd4, 5'd0);
        settle_and_check("post4");
        chk("post4_lit", 64'(rs1_data), 64'h22);
        clock_model();

        drive(32'd1 << 12, 32'hA5, 32'd1 << 12, 5'd12, 5'd9);
        settle_and_check("wr12");
        clock_model();
        reset = 1'b1;
        drive(32'd1 << 12, 32'hFF, 32'd1 << 12, 5'd12, 5'd9);
        settle_and_check("rst_mid");
        clock_model();
        reset = 1'b0;
        drive(32'd0, '0, 32'd0, 5'd12, 5'd9);
        settle_and_check("post_rst");
        chk("post_rst_data", 64'(rs1_data), 64'd0);
        chk("post_rst_bv", 64'(busy_vec), 64'd0);
        clock_model();

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            we = rand_strobe();
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0 && we != 0) begin
                for (int b = 0; b < 32; b++) if (we[b]) a1 = 5'(b);
            end
            drive(we, $urandom(), rand_strobe(), a1, a2);
            settle_and_check("rand");
            clock_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
